// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use stall control for a 3-stage EX/MEM/WB tail.
// Optional macro FWD_CTRL_PERF_EN adds a saturating 16-bit stall_count output.
package Mux3Type;
    typedef enum logic [1:0] {
        DEFAULT = 2'd0,
        TOP     = 2'd1,
        BOTTOM  = 2'd2,
        ZERO    = 2'd3
    } cmd_t;
endpackage

module fwd_ctrl #(
    parameter int unsigned REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [REG_W-1:0] issue_rs1,
    input  logic [REG_W-1:0] issue_rs2,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             issue_we,
    input  logic             issue_load,
    input  logic             hold,
    input  logic             flush,
    output Mux3Type::cmd_t   cmd_a,
    output Mux3Type::cmd_t   cmd_b,
    output logic             stall
`ifdef FWD_CTRL_PERF_EN
    ,
    output logic [15:0]      stall_count
`endif
);

    logic             ex_valid_q, ex_valid_d, ex_we_q, ex_we_d, ex_load_q, ex_load_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             mem_valid_q, mem_valid_d, mem_we_q, mem_we_d, mem_load_q, mem_load_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    Mux3Type::cmd_t   cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;

    logic ex_writing, mem_writing, hazard, accept;

    // Youngest matching producer wins; x0 always reads as zero.
    function automatic Mux3Type::cmd_t sel_cmd(
        input logic [REG_W-1:0] rs,
        input logic             ex_wr,
        input logic [REG_W-1:0] ex_rd,
        input logic             mem_wr,
        input logic [REG_W-1:0] mem_rd
    );
        if (rs == '0)                     return Mux3Type::ZERO;
        else if (ex_wr && ex_rd == rs)    return Mux3Type::TOP;
        else if (mem_wr && mem_rd == rs)  return Mux3Type::BOTTOM;
        else                              return Mux3Type::DEFAULT;
    endfunction

    always_comb begin
        ex_writing  = ex_valid_q && ex_we_q && (ex_rd_q != '0);
        mem_writing = mem_valid_q && mem_we_q && (mem_rd_q != '0);
        hazard      = ex_writing && ex_load_q && issue_valid &&
                      ((issue_rs1 == ex_rd_q) || (issue_rs2 == ex_rd_q));
        issue_ready = !hold && !flush && !hazard;
        accept      = issue_valid && issue_ready;
        stall       = issue_valid && hazard && !hold && !flush;
    end

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rd_d     = ex_rd_q;
        ex_we_d     = ex_we_q;
        ex_load_d   = ex_load_q;
        mem_valid_d = mem_valid_q;
        mem_rd_d    = mem_rd_q;
        mem_we_d    = mem_we_q;
        mem_load_d  = mem_load_q;
        cmd_a_d     = cmd_a_q;
        cmd_b_d     = cmd_b_q;
        if (flush) begin
            ex_valid_d  = 1'b0;
            mem_valid_d = 1'b0;
            cmd_a_d     = Mux3Type::DEFAULT;
            cmd_b_d     = Mux3Type::DEFAULT;
        end else if (!hold) begin
            mem_valid_d = ex_valid_q;
            mem_rd_d    = ex_rd_q;
            mem_we_d    = ex_we_q;
            mem_load_d  = ex_load_q;
            ex_valid_d  = accept;
            cmd_a_d     = Mux3Type::DEFAULT;
            cmd_b_d     = Mux3Type::DEFAULT;
            if (accept) begin
                ex_rd_d   = issue_rd;
                ex_we_d   = issue_we;
                ex_load_d = issue_load;
                cmd_a_d   = sel_cmd(issue_rs1, ex_writing, ex_rd_q, mem_writing, mem_rd_q);
                cmd_b_d   = sel_cmd(issue_rs2, ex_writing, ex_rd_q, mem_writing, mem_rd_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_load_q  <= 1'b0;
            cmd_a_q     <= Mux3Type::DEFAULT;
            cmd_b_q     <= Mux3Type::DEFAULT;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            mem_load_q  <= mem_load_d;
            cmd_a_q     <= cmd_a_d;
            cmd_b_q     <= cmd_b_d;
        end
    end

    assign cmd_a = cmd_a_q;
    assign cmd_b = cmd_b_q;

`ifdef FWD_CTRL_PERF_EN
    logic [15:0] stall_count_q, stall_count_d;

    // Saturating count of bubble cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && stall_count_q != 16'hFFFF) begin
            stall_count_d = 16'(stall_count_q + 16'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) stall_count_q <= 16'd0;
        else       stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed vector bench for fwd_ctrl: table of per-cycle inputs with expected
// ready/stall and the cmd values registered by the previous edge.
module tb_fwd_ctrl;
    import Mux3Type::*;

    logic           clk, reset, issue_valid, issue_ready;
    logic [4:0]     issue_rs1, issue_rs2, issue_rd;
    logic           issue_we, issue_load, hold, flush, stall;
    cmd_t           cmd_a, cmd_b;
`ifdef FWD_CTRL_PERF_EN
    logic [15:0]    stall_count;
`endif

    int checks = 0;
    int errors = 0;

    fwd_ctrl #(.REG_W(5)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_we(issue_we), .issue_load(issue_load),
        .hold(hold), .flush(flush),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .stall(stall)
`ifdef FWD_CTRL_PERF_EN
        , .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       we, ld, hold, flush;
        logic       e_ready, e_stall;
        cmd_t       e_a, e_b;
    } vec_t;

    localparam int NV = 41;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                                input logic we, input logic ld, input logic h, input logic f,
                                input logic er, input logic es, input cmd_t ea, input cmd_t eb);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
        r.we = we; r.ld = ld; r.hold = h; r.flush = f;
        r.e_ready = er; r.e_stall = es; r.e_a = ea; r.e_b = eb;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp_v);
        end
    endtask

    task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                         input logic we, input logic ld, input logic h, input logic f);
        issue_valid = v; issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2); issue_rd = 5'(rd);
        issue_we = we; issue_load = ld; hold = h; flush = f;
    endtask

    initial begin
        // rows: v rs1 rs2 rd we ld hold flush | ready stall cmd_a cmd_b (from previous edge)
        vecs[0]  = mk(1, 1, 2, 5, 1, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[1]  = mk(1, 5, 0, 6, 1, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, TOP, ZERO);
        vecs[3]  = mk(1, 0, 0, 7, 1, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[4]  = mk(1, 1, 2, 8, 1, 0, 0, 0, 1, 0, ZERO, ZERO);
        vecs[5]  = mk(1, 1, 7, 10, 0, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, DEFAULT, BOTTOM);
        vecs[7]  = mk(1, 0, 0, 3, 1, 1, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[8]  = mk(1, 3, 0, 11, 1, 0, 0, 0, 0, 1, ZERO, ZERO);
        vecs[9]  = mk(1, 3, 0, 11, 1, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, BOTTOM, ZERO);
        vecs[11] = mk(1, 0, 0, 4, 1, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[12] = mk(1, 0, 0, 4, 1, 0, 0, 0, 1, 0, ZERO, ZERO);
        vecs[13] = mk(1, 4, 4, 0, 1, 0, 0, 0, 1, 0, ZERO, ZERO);
        vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, TOP, TOP);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZERO, ZERO);
        vecs[16] = mk(1, 0, 0, 13, 1, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[17] = mk(1, 13, 0, 14, 1, 0, 1, 0, 0, 0, ZERO, ZERO);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ZERO, ZERO);
        vecs[19] = mk(1, 13, 13, 0, 0, 0, 0, 0, 1, 0, ZERO, ZERO);
        vecs[20] = mk(1, 0, 0, 15, 1, 1, 0, 0, 1, 0, TOP, TOP);
        vecs[21] = mk(1, 15, 0, 0, 0, 0, 1, 0, 0, 0, ZERO, ZERO);
        vecs[22] = mk(1, 15, 0, 0, 0, 0, 0, 0, 0, 1, ZERO, ZERO);
        vecs[23] = mk(1, 15, 0, 0, 0, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, BOTTOM, ZERO);
        vecs[25] = mk(1, 0, 0, 9, 1, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[26] = mk(1, 0, 0, 9, 1, 0, 0, 0, 1, 0, ZERO, ZERO);
        vecs[27] = mk(1, 9, 9, 0, 0, 0, 1, 1, 0, 0, ZERO, ZERO);
        vecs[28] = mk(1, 9, 0, 0, 0, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, DEFAULT, ZERO);
        vecs[30] = mk(1, 0, 0, 2, 1, 1, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[31] = mk(1, 2, 0, 0, 0, 0, 0, 1, 0, 0, ZERO, ZERO);
        vecs[32] = mk(1, 2, 2, 0, 0, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[33] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[34] = mk(1, 0, 0, 6, 1, 1, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[35] = mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 1, ZERO, ZERO);
        vecs[36] = mk(1, 1, 6, 0, 0, 0, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[37] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, DEFAULT, BOTTOM);
        vecs[38] = mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, DEFAULT, DEFAULT);
        vecs[39] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZERO, ZERO);
        vecs[40] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZERO, ZERO);

        // Reset asserted alongside flush, hold and a valid issue.
        reset = 1'b1;
        drive(1, 1, 1, 1, 1, 1, 1, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_ready", 0, int'(issue_ready), 1);
        chk("reset_stall", 0, int'(stall), 0);
        chk("reset_cmd_a", 0, int'(cmd_a), int'(DEFAULT));
        chk("reset_cmd_b", 0, int'(cmd_b), int'(DEFAULT));
`ifdef FWD_CTRL_PERF_EN
        chk("reset_stall_count", 0, int'(stall_count), 0);
`endif

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].v, int'(vecs[i].rs1), int'(vecs[i].rs2), int'(vecs[i].rd),
                  vecs[i].we, vecs[i].ld, vecs[i].hold, vecs[i].flush);
            #1;
            chk("issue_ready", i, int'(issue_ready), int'(vecs[i].e_ready));
            chk("stall", i, int'(stall), int'(vecs[i].e_stall));
            chk("cmd_a", i, int'(cmd_a), int'(vecs[i].e_a));
            chk("cmd_b", i, int'(cmd_b), int'(vecs[i].e_b));
        end

`ifdef FWD_CTRL_PERF_EN
        chk("stall_count_three", 0, int'(stall_count), 3);
`endif

        // Mid-stream reset must beat an issue that would otherwise forward.
        @(negedge clk);
        drive(1, 0, 0, 5, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 5, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_cmd_a", 1, int'(cmd_a), int'(DEFAULT));
        chk("midreset_cmd_b", 1, int'(cmd_b), int'(DEFAULT));
        chk("midreset_ready", 1, int'(issue_ready), 1);
`ifdef FWD_CTRL_PERF_EN
        chk("midreset_stall_count", 1, int'(stall_count), 0);
`endif
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("postreset_cmd_a", 2, int'(cmd_a), int'(DEFAULT));
        chk("postreset_cmd_b", 2, int'(cmd_b), int'(ZERO));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
